// File: rtl/bp_pkg.sv
`default_nettype none
// Shared predictor types: 2-bit bimodal counter, its saturating update and the default BTB entry layout.
package bp_pkg;

  localparam int unsigned BP_XLEN  = 32;
  localparam int unsigned BP_TAG_W = 7;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT = 2'b00;
  localparam bp_ctr_t CTR_WNT = 2'b01;
  localparam bp_ctr_t CTR_WT  = 2'b10;
  localparam bp_ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-3:0]  target;
    bp_ctr_t             ctr;
    logic                is_jump;
  } btb_entry_t;

  function automatic bp_ctr_t ctr_update(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr + 2'b01;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_array.sv
`default_nettype none
// Direct-mapped BTB storage: async lookup and training read ports, one sync write port,
// valid bits with async reset and single-cycle flush.
module btb_array
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 512,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned INDEX_W = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [XLEN-3:0]    rd_target_o,
  output bp_ctr_t            rd_ctr_o,
  output logic               rd_jump_o,
  input  logic [INDEX_W-1:0] tr_idx_i,
  output logic               tr_valid_o,
  output logic [TAG_W-1:0]   tr_tag_o,
  output bp_ctr_t            tr_ctr_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  bp_ctr_t            wr_ctr_i,
  input  logic               wr_tgt_en_i,
  input  logic [XLEN-3:0]    wr_target_i,
  input  logic               wr_jump_en_i,
  input  logic               wr_jump_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-3:0]    target_q [ENTRIES];
  bp_ctr_t            ctr_q    [ENTRIES];

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_jump_o   = jump_q[rd_idx_i];

  assign tr_valid_o  = valid_q[tr_idx_i];
  assign tr_tag_o    = tag_q[tr_idx_i];
  assign tr_ctr_o    = ctr_q[tr_idx_i];

  // Flush beats a same-cycle allocation; payload arrays are never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      ctr_q[wr_idx_i] <= wr_ctr_i;
    end
    if (wr_tgt_en_i) begin
      target_q[wr_idx_i] <= wr_target_i;
    end
    if (wr_jump_en_i) begin
      jump_q[wr_idx_i] <= wr_jump_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btb_bimodal_pc.sv
`default_nettype none
// Fetch PC generator with a direct-mapped BTB and per-entry bimodal counters,
// trained from the execute-stage resolve port.
module btb_bimodal_pc
  import bp_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ENTRIES  = 512,
  parameter int unsigned     TAG_W    = 7,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_enable,
  input  logic            dbp_disable,
  input  logic            bp_flush,
  output logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mispredict,
  output logic [31:0]     perf_hits,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d, pc_next;
  logic [31:0]        perf_hits_q, perf_hits_d;
  logic [31:0]        perf_mis_q, perf_mis_d;

  logic [INDEX_W-1:0] lk_idx, tr_idx;
  logic [TAG_W-1:0]   lk_tag, tr_tag_ex;
  logic               rd_valid, rd_jump, tr_valid, tr_hit, lk_hit;
  logic [TAG_W-1:0]   rd_tag, tr_tag;
  logic [XLEN-3:0]    rd_target;
  bp_ctr_t            rd_ctr, tr_ctr, wr_ctr;
  logic               wr_en, wr_tgt_en, wr_jump_en;

  assign lk_idx    = fetch_pc_q[INDEX_W+1:2];
  assign lk_tag    = fetch_pc_q[INDEX_W+TAG_W+1:INDEX_W+2];
  assign tr_idx    = ex_pc[INDEX_W+1:2];
  assign tr_tag_ex = ex_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  btb_array #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bp_flush),
    .rd_idx_i     (lk_idx),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_target_o  (rd_target),
    .rd_ctr_o     (rd_ctr),
    .rd_jump_o    (rd_jump),
    .tr_idx_i     (tr_idx),
    .tr_valid_o   (tr_valid),
    .tr_tag_o     (tr_tag),
    .tr_ctr_o     (tr_ctr),
    .wr_en_i      (wr_en),
    .wr_idx_i     (tr_idx),
    .wr_tag_i     (tr_tag_ex),
    .wr_ctr_i     (wr_ctr),
    .wr_tgt_en_i  (wr_tgt_en),
    .wr_target_i  (ex_target[XLEN-1:2]),
    .wr_jump_en_i (wr_jump_en),
    .wr_jump_i    (ex_is_jump)
  );

  assign lk_hit         = rd_valid & (rd_tag == lk_tag);
  assign predict_taken  = lk_hit & (rd_jump | (rd_ctr >= CTR_WT)) & ~dbp_disable;
  assign predict_target = {rd_target, 2'b00};

  always_comb begin
    if (ex_mispredict) begin
      pc_next = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end else if (predict_taken) begin
      pc_next = predict_target;
    end else begin
      pc_next = fetch_pc_q + XLEN'(4);
    end
    fetch_pc_d = (pc_enable | ex_mispredict) ? pc_next : fetch_pc_q;
  end

  // Hits retrain in place; misses allocate only when taken.
  always_comb begin
    tr_hit     = tr_valid & (tr_tag == tr_tag_ex);
    wr_en      = 1'b0;
    wr_tgt_en  = 1'b0;
    wr_jump_en = 1'b0;
    wr_ctr     = tr_ctr;
    if (ex_valid) begin
      if (tr_hit) begin
        wr_en     = 1'b1;
        wr_tgt_en = ex_is_jump | ex_taken;
        wr_ctr    = ex_is_jump ? CTR_ST : ctr_update(tr_ctr, ex_taken);
      end else if (ex_taken) begin
        wr_en      = 1'b1;
        wr_tgt_en  = 1'b1;
        wr_jump_en = 1'b1;
        wr_ctr     = ex_is_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  always_comb begin
    perf_hits_d = perf_hits_q;
    perf_mis_d  = perf_mis_q;
    if (predict_taken && pc_enable && (perf_hits_q != 32'hFFFF_FFFF)) begin
      perf_hits_d = perf_hits_q + 32'd1;
    end
    if (ex_mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
      perf_mis_d = perf_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      perf_hits_q <= '0;
      perf_mis_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      perf_hits_q <= perf_hits_d;
      perf_mis_q  <= perf_mis_d;
    end
  end

  assign fetch_pc         = fetch_pc_q;
  assign perf_hits        = perf_hits_q;
  assign perf_mispredicts = perf_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_bimodal_pc.sv
`default_nettype none
// Directed bench for btb_bimodal_pc: expectations queued per step, checked one cycle later.
module tb_btb_bimodal_pc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_enable = 1'b0;
  logic        dbp_disable = 1'b0;
  logic        bp_flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic        ex_taken = 1'b0;
  logic        ex_mispredict = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic [31:0] fetch_pc, predict_target, perf_hits, perf_mispredicts;
  logic        predict_taken;

  always #5 clk = ~clk;

  btb_bimodal_pc #(
    .XLEN     (32),
    .ENTRIES  (512),
    .TAG_W    (7),
    .RESET_PC (32'h0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_enable        (pc_enable),
    .dbp_disable      (dbp_disable),
    .bp_flush         (bp_flush),
    .fetch_pc         (fetch_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_is_jump       (ex_is_jump),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_mispredict    (ex_mispredict),
    .perf_hits        (perf_hits),
    .perf_mispredicts (perf_mispredicts)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] hits;
    logic [31:0] mis;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        cur_pt = 1'b0;
  logic [31:0] m_hits = '0;
  logic [31:0] m_mis = '0;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
    end
  endtask

  // Queue what the DUT must show after the next edge, clock it, then compare.
  task automatic step(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    exp_t e;
    if (!rst_n) begin
      m_hits = '0;
      m_mis  = '0;
    end else begin
      if (cur_pt && pc_enable) m_hits = sat(m_hits);
      if (ex_mispredict)       m_mis  = sat(m_mis);
    end
    e.tag  = tag;
    e.pc   = pc;
    e.pt   = pt;
    e.tgt  = tgt;
    e.hits = m_hits;
    e.mis  = m_mis;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, "fetch_pc", fetch_pc, e.pc);
    chk(e.tag, "predict_taken", {31'b0, predict_taken}, {31'b0, e.pt});
    if (e.pt) chk(e.tag, "predict_target", predict_target, e.tgt);
    chk(e.tag, "perf_hits", perf_hits, e.hits);
    chk(e.tag, "perf_mispredicts", perf_mispredicts, e.mis);
    cur_pt = e.pt;
  endtask

  task automatic clr();
    ex_valid      = 1'b0;
    ex_is_jump    = 1'b0;
    ex_taken      = 1'b0;
    ex_mispredict = 1'b0;
    ex_pc         = '0;
    ex_target     = '0;
    bp_flush      = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic jump, input logic taken, input logic [31:0] tgt);
    ex_valid   = 1'b1;
    ex_pc      = pc;
    ex_is_jump = jump;
    ex_taken   = taken;
    ex_target  = tgt;
  endtask

  task automatic redir(input logic [31:0] tgt);
    ex_valid      = 1'b0;
    ex_mispredict = 1'b1;
    ex_taken      = 1'b1;
    ex_target     = tgt;
    pc_enable     = 1'b0;
  endtask

  initial begin
    pc_enable = 1'b1;
    repeat (2) @(negedge clk);
    step("reset", 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step("seq1", 32'h4, 1'b0, 32'h0);
    step("seq2", 32'h8, 1'b0, 32'h0);
    step("seq3", 32'hC, 1'b0, 32'h0);

    train(32'h40, 1'b0, 1'b1, 32'h100);
    ex_mispredict = 1'b1;
    step("cond_alloc", 32'h100, 1'b0, 32'h0);
    clr();
    step("seq_after", 32'h104, 1'b0, 32'h0);
    redir(32'h40);
    step("visit40", 32'h40, 1'b1, 32'h100);
    clr();

    train(32'h40, 1'b0, 1'b0, 32'h0);
    step("nt_to_wnt", 32'h40, 1'b0, 32'h0);
    step("nt_to_snt", 32'h40, 1'b0, 32'h0);
    train(32'h40, 1'b0, 1'b1, 32'h100);
    step("t_to_wnt", 32'h40, 1'b0, 32'h0);
    step("t_to_wt", 32'h40, 1'b1, 32'h100);
    clr();
    pc_enable = 1'b1;
    step("follow_pred", 32'h100, 1'b0, 32'h0);

    pc_enable = 1'b0;
    train(32'h840, 1'b0, 1'b1, 32'h500);
    step("alias_alloc", 32'h100, 1'b0, 32'h0);
    clr();
    redir(32'h40);
    step("alias_miss40", 32'h40, 1'b0, 32'h0);
    clr();
    redir(32'h840);
    step("alias_hit840", 32'h840, 1'b1, 32'h500);
    clr();

    train(32'h200, 1'b1, 1'b1, 32'h80);
    step("jal_alloc", 32'h840, 1'b1, 32'h500);
    clr();
    redir(32'h200);
    step("jal_hit", 32'h200, 1'b1, 32'h80);
    clr();
    dbp_disable = 1'b1;
    step("dbp_hold", 32'h200, 1'b0, 32'h0);
    pc_enable = 1'b1;
    step("dbp_seq", 32'h204, 1'b0, 32'h0);
    dbp_disable = 1'b0;
    pc_enable   = 1'b0;

    ex_valid      = 1'b1;
    ex_pc         = 32'h300;
    ex_taken      = 1'b0;
    ex_mispredict = 1'b1;
    step("stall_redir", 32'h304, 1'b0, 32'h0);
    clr();
    train(32'h400, 1'b0, 1'b1, 32'h700);
    bp_flush = 1'b1;
    step("flush_alloc", 32'h304, 1'b0, 32'h0);
    clr();
    redir(32'h400);
    step("flush_miss400", 32'h400, 1'b0, 32'h0);
    clr();
    redir(32'h840);
    step("flush_miss840", 32'h840, 1'b0, 32'h0);
    clr();
    train(32'h400, 1'b0, 1'b1, 32'h700);
    step("realloc400", 32'h840, 1'b0, 32'h0);
    clr();
    redir(32'h400);
    step("hit400", 32'h400, 1'b1, 32'h700);
    clr();

    redir(32'hFFFF_FFFC);
    step("redir_top", 32'hFFFF_FFFC, 1'b0, 32'h0);
    clr();
    pc_enable = 1'b1;
    step("wrap", 32'h0, 1'b0, 32'h0);

    redir(32'h1234);
    pc_enable = 1'b1;
    rst_n     = 1'b0;
    step("rst_redir", 32'h0, 1'b0, 32'h0);
    clr();
    rst_n = 1'b1;
    redir(32'h400);
    step("rst_miss400", 32'h400, 1'b0, 32'h0);
    clr();

    force dut.perf_mis_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_mis_q;
    m_mis         = 32'hFFFF_FFFE;
    ex_valid      = 1'b1;
    ex_pc         = 32'h10;
    ex_taken      = 1'b0;
    ex_mispredict = 1'b1;
    repeat (3) step("perf_sat", 32'h14, 1'b0, 32'h0);
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
